ncc_desc_loader: RTL and testbench

Multi-slot descriptor loader for the NCC matcher. It accepts a pixel stream from the PCI ingest path over a valid/ready handshake and assembles complete descriptors in a staging register. Each finished descriptor is committed atomically into one of NUM_SLOTS storage slots, together with its pixel sum and sum of squares. The correlation datapath reads any slot combinationally while another slot is loading.

---
 rtl/ncc_desc_loader.sv | 125 ++++++++++++
 tb/tb_ncc_desc_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ncc_desc_loader.sv
// Descriptor loader: shifts a pixel stream into a staging register with running
// sum / sum-of-squares, then commits the whole descriptor atomically into a slot.
module ncc_desc_loader #(
   parameter int PIXEL_W    = 8,
   parameter int NUM_PIXELS = 256,
   parameter int NUM_SLOTS  = 4,
   localparam int DESC_W    = NUM_PIXELS * PIXEL_W,
   localparam int SLOT_W    = $clog2(NUM_SLOTS),
   localparam int CNT_W     = $clog2(NUM_PIXELS + 1),
   localparam int SUM_W     = PIXEL_W + CNT_W,
   localparam int SUMSQ_W   = 2 * PIXEL_W + CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SLOT_W-1:0]    startSlot,
   input  logic                 abort,
   input  logic [PIXEL_W-1:0]   pixIn,
   input  logic                 pixValid,
   output logic                 pixReady,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_SLOTS-1:0] slotValid,
   input  logic [SLOT_W-1:0]    rdSlot,
   output logic [DESC_W-1:0]    descOut,
   output logic [SUM_W-1:0]     sumOut,
   output logic [SUMSQ_W-1:0]   sumSqOut
);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t                 state;
   logic                   done_reg;
   logic [SLOT_W-1:0]      target;
   logic [DESC_W-1:0]      stage;
   logic [SUM_W-1:0]       stage_sum;
   logic [SUMSQ_W-1:0]     stage_sumsq;
   logic [CNT_W-1:0]       count;
   logic [NUM_SLOTS-1:0]   slot_valid;

   logic [DESC_W-1:0]      slot_desc  [NUM_SLOTS];
   logic [SUM_W-1:0]       slot_sum   [NUM_SLOTS];
   logic [SUMSQ_W-1:0]     slot_sumsq [NUM_SLOTS];

   logic                   start_ok;
   logic                   rd_ok;
   logic [SUMSQ_W-1:0]     pix_ext;

   // Slot indices are zero-extended so non-power-of-two slot counts range-check correctly.
   assign start_ok = ({{(32-SLOT_W){1'b0}}, startSlot} < 32'(NUM_SLOTS));
   assign rd_ok    = ({{(32-SLOT_W){1'b0}}, rdSlot} < 32'(NUM_SLOTS));
   assign pix_ext  = SUMSQ_W'(pixIn);

   assign pixReady  = (state == LOAD);
   assign busy      = (state != IDLE);
   assign done      = done_reg;
   assign slotValid = slot_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done_reg    <= 1'b0;
         target      <= '0;
         stage       <= '0;
         stage_sum   <= '0;
         stage_sumsq <= '0;
         count       <= '0;
         slot_valid  <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_desc[i]  <= '0;
            slot_sum[i]   <= '0;
            slot_sumsq[i] <= '0;
         end
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (start && start_ok) begin
                  target             <= startSlot;
                  stage              <= '0;
                  stage_sum          <= '0;
                  stage_sumsq        <= '0;
                  count              <= '0;
                  slot_valid[startSlot] <= 1'b0;
                  state              <= LOAD;
               end
            end
            LOAD: begin
               // abort has priority: a pixel offered in the same cycle is dropped
               if (abort) begin
                  state <= IDLE;
               end else if (pixValid) begin
                  stage       <= {stage[DESC_W-PIXEL_W-1:0], pixIn};
                  stage_sum   <= stage_sum + SUM_W'(pixIn);
                  stage_sumsq <= stage_sumsq + pix_ext * pix_ext;
                  count       <= count + CNT_W'(1);
                  if (count == CNT_W'(NUM_PIXELS - 1))
                     state <= COMMIT;
               end
            end
            COMMIT: begin
               slot_desc[target]  <= stage;
               slot_sum[target]   <= stage_sum;
               slot_sumsq[target] <= stage_sumsq;
               slot_valid[target] <= 1'b1;
               done_reg           <= 1'b1;
               state              <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      descOut  = '0;
      sumOut   = '0;
      sumSqOut = '0;
      if (rd_ok) begin
         descOut  = slot_desc[rdSlot];
         sumOut   = slot_sum[rdSlot];
         sumSqOut = slot_sumsq[rdSlot];
      end
   end

endmodule

// File: tb/tb_ncc_desc_loader.sv
// Directed bench for ncc_desc_loader with 4-pixel descriptors and 4 slots.
module tb_ncc_desc_loader;

   localparam int PIXEL_W    = 8;
   localparam int NUM_PIXELS = 4;
   localparam int NUM_SLOTS  = 4;
   localparam int DESC_W     = NUM_PIXELS * PIXEL_W;
   localparam int SLOT_W     = $clog2(NUM_SLOTS);
   localparam int CNT_W      = $clog2(NUM_PIXELS + 1);
   localparam int SUM_W      = PIXEL_W + CNT_W;
   localparam int SUMSQ_W    = 2 * PIXEL_W + CNT_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [SLOT_W-1:0]    startSlot;
   logic                 abort;
   logic [PIXEL_W-1:0]   pixIn;
   logic                 pixValid;
   logic                 pixReady;
   logic                 busy;
   logic                 done;
   logic [NUM_SLOTS-1:0] slotValid;
   logic [SLOT_W-1:0]    rdSlot;
   logic [DESC_W-1:0]    descOut;
   logic [SUM_W-1:0]     sumOut;
   logic [SUMSQ_W-1:0]   sumSqOut;

   int checks = 0;
   int errors = 0;

   ncc_desc_loader #(
      .PIXEL_W(PIXEL_W), .NUM_PIXELS(NUM_PIXELS), .NUM_SLOTS(NUM_SLOTS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .startSlot(startSlot), .abort(abort),
      .pixIn(pixIn), .pixValid(pixValid), .pixReady(pixReady), .busy(busy),
      .done(done), .slotValid(slotValid), .rdSlot(rdSlot), .descOut(descOut),
      .sumOut(sumOut), .sumSqOut(sumSqOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic read_slot(input int s, input logic [31:0] d, input int sm, input int sq);
      rdSlot = SLOT_W'(s);
      #1;
      chk($sformatf("desc[%0d]", s), 64'(descOut), 64'(d));
      chk($sformatf("sum[%0d]", s), 64'(sumOut), 64'(sm));
      chk($sformatf("sumsq[%0d]", s), 64'(sumSqOut), 64'(sq));
   endtask

   // Called at a negedge; returns at the negedge of the first LOAD cycle.
   task automatic do_start(input int s);
      start = 1'b1;
      startSlot = SLOT_W'(s);
      @(negedge clk);
      start = 1'b0;
      chk("pixReady_after_start", 64'(pixReady), 64'd1);
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic push(input logic [7:0] p, input bit gap);
      if (gap) begin
         pixValid = 1'b0;
         @(negedge clk);
         chk("pixReady_in_gap", 64'(pixReady), 64'd1);
      end
      pixValid = 1'b1;
      pixIn = p;
      @(negedge clk);
      pixValid = 1'b0;
   endtask

   // Entered in the cycle after the last accept; returns in the done cycle.
   task automatic commit_check(input logic [3:0] exp_valid);
      chk("commit_pixReady", 64'(pixReady), 64'd0);
      chk("commit_busy", 64'(busy), 64'd1);
      chk("commit_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_busy", 64'(busy), 64'd0);
      chk("slotValid", 64'(slotValid), 64'(exp_valid));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; startSlot = '0; abort = 1'b0;
      pixIn = '0; pixValid = 1'b0; rdSlot = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_slotValid", 64'(slotValid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pixReady", 64'(pixReady), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      for (int s = 0; s < 4; s++) read_slot(s, 32'h0, 0, 0);

      // slot 2, continuous stream
      do_start(2);
      push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'hFF, 0);
      commit_check(4'b0100);
      read_slot(2, 32'h010203FF, 261, 65039);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);

      // reload slot 2 with gaps; old data persists during the load
      do_start(2);
      chk("reload_clears_valid", 64'(slotValid), 64'd0);
      read_slot(2, 32'h010203FF, 261, 65039);
      push(8'h01, 1); push(8'h02, 1); push(8'h03, 1); push(8'hFF, 1);
      commit_check(4'b0100);
      read_slot(2, 32'h010203FF, 261, 65039);
      @(negedge clk);

      // slot 1 loaded, then reload aborted after 2 pixels
      do_start(1);
      push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
      commit_check(4'b0110);
      @(negedge clk);
      do_start(1);
      push(8'h55, 0); push(8'h66, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_pixReady", 64'(pixReady), 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_done", 64'(done), 64'd0);
         @(negedge clk);
      end
      chk("abort_slotValid", 64'(slotValid), 64'b0100);
      read_slot(1, 32'h11223344, 170, 8670);

      // start during LOAD is ignored: load into slot 0 completes undisturbed
      do_start(0);
      push(8'hA0, 0);
      start = 1'b1; startSlot = 2'd3;
      push(8'hA1, 0);
      start = 1'b0;
      push(8'hA2, 0); push(8'hA3, 0);
      commit_check(4'b0101);
      read_slot(0, 32'hA0A1A2A3, 646, 104334);
      read_slot(3, 32'h0, 0, 0);
      @(negedge clk);

      // abort with a valid pixel that would have been the last one
      do_start(3);
      push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
      abort = 1'b1; pixValid = 1'b1; pixIn = 8'h04;
      @(negedge clk);
      abort = 1'b0; pixValid = 1'b0;
      chk("abort_pix_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("abort_pix_done", 64'(done), 64'd0);
      chk("abort_pix_slotValid", 64'(slotValid), 64'b0101);
      read_slot(3, 32'h0, 0, 0);

      // reset in mid-load of slot 3
      do_start(3);
      push(8'h77, 0); push(8'h88, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_slotValid", 64'(slotValid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("midrst_done", 64'(done), 64'd0);
      for (int s = 0; s < 4; s++) read_slot(s, 32'h0, 0, 0);

      // back-to-back: start slot 1 in slot 0's done cycle
      do_start(0);
      push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0);
      commit_check(4'b0001);
      do_start(1);
      push(8'h10, 0); push(8'h20, 0); push(8'h30, 0); push(8'h40, 0);
      commit_check(4'b0011);
      read_slot(0, 32'h01020304, 10, 30);
      read_slot(1, 32'h10203040, 160, 7680);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
